// File: rtl/life_row_sequencer.sv
// One Game-of-Life generation over a ROWS x 32 grid: streams source rows through a
// three-row window feeding the external neighbour-count adder and writes each next row.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | issue source read for row f
// CAP   | shift read data into the window
// EVAL  | apply rule to window middle row, write it
// FLUSH | shift a zero row in below the last grid row
// DONE  | pulse done, count the generation
module life_row_sequencer #(
    parameter int ROWS = 32,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [15:0]   gen,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [31:0]   rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic [31:0]   r1,
    output logic [31:0]   r2,
    output logic [31:0]   r3,
    input  logic [119:0]  cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAP,
        S_EVAL,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [AW:0]   ROWS_F = (AW+1)'(ROWS);
    localparam logic [AW-1:0] LAST_E = AW'(ROWS - 1);

    state_t        state_q, state_d;
    logic [31:0]   top_q, top_d;
    logic [31:0]   mid_q, mid_d;
    logic [31:0]   bot_q, bot_d;
    logic [AW:0]   f_q, f_d;
    logic [AW-1:0] e_q, e_d;
    logic [15:0]   gen_q, gen_d;
    logic [31:0]   next_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            top_q   <= '0;
            mid_q   <= '0;
            bot_q   <= '0;
            f_q     <= '0;
            e_q     <= '0;
            gen_q   <= '0;
        end else begin
            state_q <= state_d;
            top_q   <= top_d;
            mid_q   <= mid_d;
            bot_q   <= bot_d;
            f_q     <= f_d;
            e_q     <= e_d;
            gen_q   <= gen_d;
        end
    end

    // Birth on exactly 3 neighbours, survival on 2 or 3; edge columns stay dead.
    always_comb begin
        next_row = '0;
        for (int k = 1; k <= 30; k++) begin
            next_row[k] = (cnt[4*(k-1) +: 4] == 4'd3) |
                          (mid_q[k] & (cnt[4*(k-1) +: 4] == 4'd2));
        end
    end

    always_comb begin
        state_d = state_q;
        top_d   = top_q;
        mid_d   = mid_q;
        bot_d   = bot_q;
        f_d     = f_q;
        e_d     = e_q;
        gen_d   = gen_q;
        done    = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    top_d   = '0;
                    mid_d   = '0;
                    bot_d   = '0;
                    f_d     = '0;
                    e_d     = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                rd_en   = 1'b1;
                rd_addr = f_q[AW-1:0];
                state_d = S_CAP;
            end
            S_CAP: begin
                top_d   = mid_q;
                mid_d   = bot_q;
                bot_d   = rd_data;
                f_d     = f_q + 1'b1;
                // Row 0 alone is not enough to evaluate anything yet.
                state_d = (f_q == '0) ? S_REQ : S_EVAL;
            end
            S_EVAL: begin
                wr_en   = 1'b1;
                wr_addr = e_q;
                wr_data = next_row;
                if (e_q == LAST_E) begin
                    state_d = S_DONE;
                end else begin
                    e_d     = e_q + 1'b1;
                    state_d = (f_q == ROWS_F) ? S_FLUSH : S_REQ;
                end
            end
            S_FLUSH: begin
                top_d   = mid_q;
                mid_d   = bot_q;
                bot_d   = '0;
                state_d = S_EVAL;
            end
            S_DONE: begin
                done    = 1'b1;
                gen_d   = gen_q + 16'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign gen  = gen_q;
    assign r1   = top_q;
    assign r2   = mid_q;
    assign r3   = bot_q;

endmodule

// File: tb/tb_life_row_sequencer.sv
// Scoreboard bench for life_row_sequencer: a source memory and neighbour-count adder
// model surround the DUT; expected row writes are queued at launch and popped by a monitor.
module tb_life_row_sequencer;
    localparam int ROWS = 32;
    localparam int AW   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, rd_en, wr_en;
    logic [15:0]   gen;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [31:0]   rd_data = '0;
    logic [31:0]   wr_data, r1, r2, r3;
    logic [119:0]  cnt;

    life_row_sequencer #(.ROWS(ROWS), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .gen(gen),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .r1(r1), .r2(r2), .r3(r3), .cnt(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] src [ROWS];
    logic [31:0] exp_rows [ROWS];
    wr_t         exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          done_base = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) rd_data <= src[rd_addr];
    end

    // Neighbour-count adder: 8 surrounding cells of r2[k], k = 1..30.
    always_comb begin
        cnt = '0;
        for (int k = 1; k <= 30; k++) begin
            int s;
            s = int'(r1[k-1]) + int'(r1[k]) + int'(r1[k+1]) + int'(r2[k-1]) + int'(r2[k+1])
              + int'(r3[k-1]) + int'(r3[k]) + int'(r3[k+1]);
            cnt[4*(k-1) +: 4] = 4'(s);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                int e;
                wr_t w;
                e = int'(wr_addr);
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(e), 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", 32'(e), 32'(w.addr));
                    chk($sformatf("wr_data[%0d]", w.addr), wr_data, w.data);
                end
                chk("window_r1", r1, (e == 0) ? 32'h0 : src[e-1]);
                chk("window_r2", r2, src[e]);
                chk("window_r3", r3, (e == ROWS-1) ? 32'h0 : src[e+1]);
            end
            if (done) begin
                done_cnt++;
                chk("done_cycle", 32'(cyc - start_cyc + 1), 32'(3*ROWS + 2));
            end
        end
    end

    task automatic clear_grid();
        for (int i = 0; i < ROWS; i++) begin
            src[i]      = '0;
            exp_rows[i] = '0;
        end
    endtask

    task automatic launch();
        exp_q.delete();
        for (int i = 0; i < ROWS; i++) exp_q.push_back('{addr: i, data: exp_rows[i]});
        wr_cnt    = 0;
        done_base = done_cnt;
        @(posedge clk); #2;
        start     = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int pa, input int pb, input logic [15:0] gen_exp);
        for (int i = 0; i < 300; i++) begin
            int n;
            @(posedge clk); #2;
            n = cyc - start_cyc;
            start = (n == pa) || (n == pb);
            if (done_cnt != done_base) break;
        end
        start = 1'b0;
        chk("done_seen", 32'(done_cnt - done_base), 32'd1);
        chk("gen", 32'(gen), 32'(gen_exp));
        repeat (10) @(posedge clk);
        #2;
        chk("busy_after", 32'(busy), 32'd0);
        chk("done_once", 32'(done_cnt - done_base), 32'd1);
        chk("write_count", 32'(wr_cnt), 32'(ROWS));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        clear_grid();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_gen", 32'(gen), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_r1", r1, 32'd0);
        chk("rst_r2", r2, 32'd0);
        chk("rst_r3", r3, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // all-zero grid
        launch();
        wait_done(-1, -1, 16'd1);

        // blinker
        clear_grid();
        src[10] = 32'h0000_0020; src[11] = 32'h0000_0020; src[12] = 32'h0000_0020;
        exp_rows[11] = 32'h0000_0070;
        launch();
        wait_done(-1, -1, 16'd2);

        // block still life
        clear_grid();
        src[3] = 32'h0000_000C; src[4] = 32'h0000_000C;
        exp_rows[3] = 32'h0000_000C; exp_rows[4] = 32'h0000_000C;
        launch();
        wait_done(-1, -1, 16'd3);

        // full row: edge columns forced dead, neighbours born
        clear_grid();
        src[5] = 32'hFFFF_FFFF;
        exp_rows[4] = 32'h7FFF_FFFE; exp_rows[5] = 32'h7FFF_FFFE; exp_rows[6] = 32'h7FFF_FFFE;
        launch();
        wait_done(-1, -1, 16'd4);

        // start pulses while busy are ignored
        clear_grid();
        launch();
        wait_done(9, 49, 16'd5);

        // reset mid-run
        clear_grid();
        src[10] = 32'h0000_0020; src[11] = 32'h0000_0020; src[12] = 32'h0000_0020;
        exp_rows[11] = 32'h0000_0070;
        launch();
        for (int i = 0; i < 100; i++) begin
            if (cyc - start_cyc >= 39) break;
            @(posedge clk);
        end
        #2;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_gen", 32'(gen), 32'd0);
        chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_wr_data", wr_data, 32'd0);
        chk("mid_rst_r2", r2, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        wr_cnt = 0;
        repeat (20) @(posedge clk);
        #2;
        chk("post_rst_writes", 32'(wr_cnt), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        launch();
        wait_done(-1, -1, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
